// File: rtl/ofdm_rx_frame_sched.sv
//-----------------------------------------------------------------------------
// ofdm_rx_frame_sched
//
// Frame-level sequencer for the 802.11 OFDM receive chain.  A host hands over
// one frame configuration (modulation + number of data symbols).  The
// scheduler then:
//   - drives the demapper QAM/QPSK selects,
//   - opens the sample gate between the front end and the Synch stage while
//     the preamble and data symbols stream through,
//   - counts demapper output words to find the end of the frame,
//   - reports frame_done, or err_timeout if the pipeline stalls.
//
// State sequence: IDLE -> PREAMBLE -> DATA -> FLUSH -> DONE -> IDLE.
//
// Optional feature (compile-time macro RX_SCHED_ABORT_EN):
//   adds abort_i / frame_abort for a host-initiated frame abort.  The default
//   build (macro undefined) has neither port.
//
// Ports:
//   CLK_I, RST_I            clock / asynchronous active-high reset
//   cfg_valid, cfg_ready    config handshake (accepted only in IDLE)
//   cfg_mode, cfg_nsym      01=QPSK, 10=16-QAM; number of data symbols (>0)
//   cfg_err                 one-cycle pulse on a rejected config
//   STB_I, CYC_I, ACK_O     front-end side of the sample bus
//   STB_O, CYC_O, ACK_I     Synch side of the sample bus
//   DEM_STB_I, DEM_ACK_I    demapper output handshake (observed only)
//   QAM, QPSK               demapper modulation selects
//   busy                    high whenever not IDLE
//   sym_cnt                 symbols accepted in this frame, preamble included
//   frame_done              one-cycle pulse at end of frame
//   err_timeout             one-cycle pulse on watchdog abort
//   abort_i, frame_abort    (RX_SCHED_ABORT_EN only) abort request / pulse
//   dbg_state_o             current FSM state, for debug and checkers
//
// Handshake semantics: a transfer happens on a rising edge where the strobe
// and the ack of the same link are both high (STB_I & ACK_I for samples,
// DEM_STB_I & DEM_ACK_I for demapper words, cfg_valid & cfg_ready for
// configs).  Strobes are never qualified by the scheduler other than through
// the sample gate.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ofdm_rx_frame_sched #(
   parameter int unsigned N_FFT       = 64,
   parameter int unsigned N_CP        = 16,
   parameter int unsigned N_PRE_SYM   = 2,
   parameter int unsigned OUT_PER_SYM = 48,
   parameter int unsigned TIMEOUT     = 4096
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [1:0] cfg_mode,
   input  logic [7:0] cfg_nsym,
   output logic       cfg_err,
   input  logic       STB_I,
   input  logic       CYC_I,
   output logic       ACK_O,
   output logic       STB_O,
   output logic       CYC_O,
   input  logic       ACK_I,
   input  logic       DEM_STB_I,
   input  logic       DEM_ACK_I,
   output logic       QAM,
   output logic       QPSK,
   output logic       busy,
   output logic [7:0] sym_cnt,
   output logic       frame_done,
   output logic       err_timeout,
`ifdef RX_SCHED_ABORT_EN
   input  logic       abort_i,
   output logic       frame_abort,
`endif
   output logic [2:0] dbg_state_o
);

   localparam int unsigned SYM_LEN = N_FFT + N_CP;
   localparam int unsigned SW      = $clog2(SYM_LEN);
   localparam int unsigned WDW     = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_DATA  = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state_q;
   logic [SW-1:0]   samp_cnt_q, samp_cnt_d;
   // One bit wider than the port so N_PRE_SYM + 255 cannot wrap.
   logic [8:0]      sym_cnt_q, sym_cnt_d;
   logic [15:0]     out_cnt_q, out_cnt_d;
   logic [WDW-1:0]  wd_cnt_q, wd_cnt_d;
   logic [7:0]      nsym_q;
   logic [15:0]     target_q;
   logic            qam_q, qpsk_q;
   logic            cfg_err_q, frame_done_q, err_timeout_q;
`ifdef RX_SCHED_ABORT_EN
   logic            frame_abort_q;
`endif

   logic            gate_open, out_open, in_hs, out_hs, sym_wrap;
   logic            wd_expire, cfg_ok;
   logic [8:0]      frame_syms;

   //--------------------------------------------------------------------------
   // Combinational datapath
   //--------------------------------------------------------------------------
   always_comb begin
      gate_open  = (state_q == S_PRE) || (state_q == S_DATA);
      out_open   = gate_open || (state_q == S_FLUSH);
      in_hs      = gate_open & STB_I & ACK_I;
      out_hs     = out_open & DEM_STB_I & DEM_ACK_I;
      sym_wrap   = in_hs && (samp_cnt_q == SW'(SYM_LEN - 1));
      frame_syms = 9'(N_PRE_SYM) + {1'b0, nsym_q};
      cfg_ok     = ((cfg_mode == 2'b01) || (cfg_mode == 2'b10)) && (cfg_nsym != 8'd0);

      samp_cnt_d = samp_cnt_q;
      if (in_hs) begin
         samp_cnt_d = sym_wrap ? '0 : samp_cnt_q + 1'b1;
      end
      sym_cnt_d = sym_wrap ? sym_cnt_q + 1'b1 : sym_cnt_q;
      out_cnt_d = out_hs ? out_cnt_q + 1'b1 : out_cnt_q;

      // Watchdog only runs while a transfer could still make progress; DONE
      // always leaves after one cycle so it is excluded.
      wd_cnt_d  = (in_hs || out_hs) ? '0 : wd_cnt_q + 1'b1;
      wd_expire = out_open && !in_hs && !out_hs && (wd_cnt_q == WDW'(TIMEOUT - 1));
   end

   // The gate is decoded straight from the state register, so an async reset
   // closes it in the same instant.
   assign STB_O = gate_open & STB_I;
   assign CYC_O = gate_open & CYC_I;
   assign ACK_O = gate_open & ACK_I;

   //--------------------------------------------------------------------------
   // Frame FSM and counters
   //--------------------------------------------------------------------------
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q       <= S_IDLE;
         samp_cnt_q    <= '0;
         sym_cnt_q     <= '0;
         out_cnt_q     <= '0;
         wd_cnt_q      <= '0;
         nsym_q        <= '0;
         target_q      <= '0;
         qam_q         <= 1'b0;
         qpsk_q        <= 1'b0;
         cfg_err_q     <= 1'b0;
         frame_done_q  <= 1'b0;
         err_timeout_q <= 1'b0;
`ifdef RX_SCHED_ABORT_EN
         frame_abort_q <= 1'b0;
`endif
      end else begin
         cfg_err_q     <= 1'b0;
         frame_done_q  <= 1'b0;
         err_timeout_q <= 1'b0;
`ifdef RX_SCHED_ABORT_EN
         frame_abort_q <= 1'b0;
`endif

         if (out_open) begin
            samp_cnt_q <= samp_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
         end

         case (state_q)
            S_IDLE: begin
               if (cfg_valid) begin
                  if (cfg_ok) begin
                     nsym_q     <= cfg_nsym;
                     target_q   <= 16'(cfg_nsym) * 16'(OUT_PER_SYM);
                     qam_q      <= cfg_mode[1];
                     qpsk_q     <= cfg_mode[0];
                     samp_cnt_q <= '0;
                     sym_cnt_q  <= '0;
                     out_cnt_q  <= '0;
                     wd_cnt_q   <= '0;
                     state_q    <= S_PRE;
                  end else begin
                     cfg_err_q  <= 1'b1;
                  end
               end
            end
            S_PRE: begin
               if (sym_wrap && (sym_cnt_d == 9'(N_PRE_SYM))) begin
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (sym_wrap && (sym_cnt_d == frame_syms)) begin
                  state_q <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               // Also covers a target already met before FLUSH was entered.
               if (out_cnt_d >= target_q) begin
                  state_q      <= S_DONE;
                  frame_done_q <= 1'b1;
               end
            end
            S_DONE: begin
               // sym_cnt is kept so the host can read the final symbol count.
               state_q    <= S_IDLE;
               samp_cnt_q <= '0;
               out_cnt_q  <= '0;
               wd_cnt_q   <= '0;
            end
            default: state_q <= S_IDLE;
         endcase

         if (wd_expire) begin
            state_q       <= S_IDLE;
            samp_cnt_q    <= '0;
            sym_cnt_q     <= '0;
            out_cnt_q     <= '0;
            wd_cnt_q      <= '0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b1;
         end

`ifdef RX_SCHED_ABORT_EN
         // Host abort wins over both normal completion and the watchdog.
         if (abort_i && (state_q != S_IDLE)) begin
            state_q       <= S_IDLE;
            samp_cnt_q    <= '0;
            sym_cnt_q     <= '0;
            out_cnt_q     <= '0;
            wd_cnt_q      <= '0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            frame_abort_q <= 1'b1;
         end
`endif
      end
   end

   assign cfg_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign QAM         = qam_q;
   assign QPSK        = qpsk_q;
   assign sym_cnt     = sym_cnt_q[7:0];
   assign cfg_err     = cfg_err_q;
   assign frame_done  = frame_done_q;
   assign err_timeout = err_timeout_q;
`ifdef RX_SCHED_ABORT_EN
   assign frame_abort = frame_abort_q;
`endif
   assign dbg_state_o = state_q;

endmodule

// File: doc/ofdm_rx_frame_sched.md
Name: ofdm_rx_frame_sched

Overview:
Frame-level sequencer for the 802.11 OFDM receive chain.
- Accepts a per-frame configuration: modulation and number of data symbols.
- Drives the demapper QAM/QPSK selects.
- Gates the sample handshake between the front end and the Synch stage.
- Counts demapper output words to detect end of frame, then signals done or timeout.
- Sits between host/config logic and the RX Wishbone-style pipeline.
- Mode changes only at frame boundaries.

Parameters:
N_FFT, 64, FFT length in samples
N_CP, 16, cyclic-prefix length in samples
N_PRE_SYM, 2, long-training symbols preceding data
OUT_PER_SYM, 48, demapper output words per data symbol
TIMEOUT, 4096, idle-cycle limit before abort (no handshake in either direction)

Ports:
CLK_I  in  1  clock, all logic on rising edge
RST_I  in  1  reset, asynchronous, active-high
cfg_valid  in  1  config request
cfg_ready  out  1  scheduler accepts config
cfg_mode  in  2  01=QPSK, 10=16-QAM; 00/11 invalid
cfg_nsym  in  8  data symbols in frame; 0 invalid
cfg_err  out  1  one-cycle pulse on rejected config
STB_I  in  1  front-end sample strobe
CYC_I  in  1  front-end cycle
ACK_O  out  1  ack to front end
STB_O  out  1  gated strobe to Synch
CYC_O  out  1  gated cycle to Synch
ACK_I  in  1  ack from Synch
DEM_STB_I  in  1  demapper output strobe (monitor only)
DEM_ACK_I  in  1  downstream ack of demapper output (monitor only)
QAM  out  1  16-QAM select to demapper/sy2bit
QPSK  out  1  QPSK select to demapper/sy2bit
busy  out  1  high in any state other than IDLE
sym_cnt  out  8  symbols accepted in current frame, preamble included
frame_done  out  1  one-cycle pulse at end of frame
err_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: all outputs 0 except cfg_ready=1. State=IDLE, all counters 0.
- States and transitions: IDLE -> PREAMBLE -> DATA -> FLUSH -> DONE -> IDLE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid with a valid mode and nonzero nsym: latch nsym; register QAM=mode[1], QPSK=mode[0]; go to PREAMBLE next cycle.
  - On cfg_valid with an invalid request: cfg_err pulses, stay in IDLE, QAM/QPSK unchanged.
- Outside IDLE, cfg_ready=0 and cfg_valid is ignored.
- QAM/QPSK change only on an accepted config and hold their value after the frame ends.
- Gating is combinational:
  - In PREAMBLE/DATA: STB_O=STB_I, CYC_O=CYC_I, ACK_O=ACK_I.
  - In all other states: STB_O=CYC_O=ACK_O=0.
- Input handshake (in PREAMBLE/DATA) = STB_I & ACK_I.
  - Sample counter runs 0..N_FFT+N_CP-1 and wraps to 0.
  - sym_cnt increments on the wrap.
- PREAMBLE -> DATA on the wrap that makes sym_cnt=N_PRE_SYM.
- DATA -> FLUSH on the wrap that makes sym_cnt=N_PRE_SYM+nsym. The input gate closes the following cycle.
- Output counter:
  - 16-bit; increments on DEM_STB_I & DEM_ACK_I in PREAMBLE, DATA and FLUSH.
  - Target = nsym*OUT_PER_SYM, computed at config accept.
  - When the count reaches the target while in FLUSH: go to DONE.
  - If the target is reached before FLUSH, move to DONE immediately on entering FLUSH.
  - Output and input handshakes in the same cycle are both counted.
- DONE: frame_done=1 for exactly one cycle; next cycle IDLE with counters cleared. sym_cnt holds its final value until the next config is accepted.
- Watchdog:
  - Counts cycles with no input or output handshake while not in IDLE.
  - Clears on any handshake.
  - At TIMEOUT: err_timeout pulses, state goes to IDLE, counters clear, frame_done stays 0.
- RST_I asserted mid-frame: immediate return to reset values. The gate closes asynchronously.

Optional Feature:
RX_SCHED_ABORT_EN
- Enabled:
  - Adds input abort_i (1 bit) and output frame_abort (1 bit).
  - abort_i high in any non-IDLE state: next state IDLE, counters cleared, frame_abort pulses one cycle.
  - abort_i has priority over DONE and over the timeout in the same cycle.
- Disabled: neither port exists; behaviour is as above.

Test Plan:
- Reset, then cfg_mode=01, nsym=3; 400 samples with ACK_I=1; 144 output handshakes -> QPSK=1, QAM=0; PREAMBLE->DATA at sample 160; gate closes after sample 400; frame_done pulses once after output word 144; sym_cnt=5.
- cfg_mode=00 or nsym=0 -> cfg_err pulse, state stays IDLE, QAM/QPSK unchanged; STB_I passes nothing (STB_O=0).
- Second cfg_valid with mode=10 issued during DATA -> ignored, QPSK stays 1. The same request after done -> QAM=1, QPSK=0.
- Stall the output after 100 words for 4096 cycles -> err_timeout at cycle 4096, busy=0, no frame_done.
- RST_I asserted during DATA (sample 250) -> all outputs at reset values in the same cycle; a new config is accepted afterwards.
- With RX_SCHED_ABORT_EN: abort_i in the same cycle as the final output handshake -> frame_abort=1, frame_done=0.
